spi_lfsr_master: RTL and testbench

SPI master controller that shares one SPI LFSR slave between two on-chip requesters. Each grant runs one 8-bit mode-0 transaction: chip select asserted, 8 SCLK periods generated from the system clock, and the returned byte delivered with the requester's ID. Sits between the requester logic, such as the test harness or a consumer block, and the off-block SPI pins of the LFSR slave.

---
 rtl/spi_lfsr_master.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_lfsr_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_lfsr_master.sv
// ---------------------------------------------------------------------------
// spi_lfsr_master
//
// SPI mode-0 master shared by two on-chip requesters. Each grant runs one
// 8-bit transaction to the LFSR slave and returns the byte with the owner ID.
// Arbitration is round-robin on a last-served pointer.
//
// Parameters
//   CLK_DIV   system clocks per SCLK half-period (2..255)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[1:0]   level request per requester
//   tx_data0   byte sent when requester 0 is granted
//   tx_data1   byte sent when requester 1 is granted
//   gnt[1:0]   one-hot, one-cycle grant pulse
//   busy       high whenever the FSM is not IDLE
//   rd_valid   one-cycle pulse, rd_data/rd_id valid
//   rd_data    received byte, held until the next rd_valid
//   rd_id      requester owning rd_data
//   spi_cs     active-low chip select
//   spi_sclk   serial clock, idle low
//   spi_mosi   master data out
//   spi_miso   slave data in
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cs high, waiting for any req
// SETUP | cs low, first MOSI bit presented, one half-period before SCLK
// SHIFT | SCLK toggling; sample on rise, present next bit on fall
// HOLD  | cs high for one half-period before the next grant is possible
// ---------------------------------------------------------------------------
module spi_lfsr_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_id,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] div_cnt;
  logic [3:0] tog_cnt;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic       last_id;

  logic       div_end;
  logic       win_id;
  logic       grant;
  logic       do_rise;
  logic       do_fall;
  logic       done;

  assign div_end = (div_cnt == DIV_LAST);
  assign busy    = (state != IDLE);

  // Round-robin: on a tie the requester not served last wins. The pointer
  // resets to 1 so requester 0 wins the first tie.
  always_comb begin
    win_id = 1'b0;
    case (req)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ~last_id;
      default: win_id = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The SETUP exit edge is the first SCLK rise; tog_cnt therefore counts
  // toggles already made, and the fall seen with tog_cnt==15 is the 16th.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    do_rise   = 1'b0;
    do_fall   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (div_end) begin
          do_rise   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (div_end) begin
          if (!spi_sclk) begin
            do_rise = 1'b1;
          end else if (tog_cnt == 4'd15) begin
            done      = 1'b1;
            state_nxt = HOLD;
          end else begin
            do_fall = 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase timer, shared by SETUP, SHIFT and HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
    end else if (grant || div_end || (state == IDLE)) begin
      div_cnt <= 8'd0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_cnt <= 4'd0;
    end else if (grant) begin
      tog_cnt <= 4'd0;
    end else if (do_rise || do_fall) begin
      tog_cnt <= tog_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= 2'b00;
      last_id <= 1'b1;
    end else begin
      gnt <= 2'b00;
      if (grant) begin
        gnt     <= win_id ? 2'b10 : 2'b01;
        last_id <= win_id;
      end
    end
  end

  // Transmit path: bit 7 goes out with the grant, later bits on each fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh    <= 8'd0;
      spi_mosi <= 1'b0;
    end else if (grant) begin
      tx_sh    <= win_id ? tx_data1 : tx_data0;
      spi_mosi <= win_id ? tx_data1[7] : tx_data0[7];
    end else if (do_fall) begin
      tx_sh    <= {tx_sh[6:0], 1'b0};
      spi_mosi <= tx_sh[6];
    end else if (done) begin
      spi_mosi <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh <= 8'd0;
    end else if (grant) begin
      rx_sh <= 8'd0;
    end else if (do_rise) begin
      rx_sh <= {rx_sh[6:0], spi_miso};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_cs   <= 1'b1;
      spi_sclk <= 1'b0;
    end else begin
      if (grant) begin
        spi_cs <= 1'b0;
      end else if (done) begin
        spi_cs <= 1'b1;
      end
      if (do_rise) begin
        spi_sclk <= 1'b1;
      end else if (do_fall || done) begin
        spi_sclk <= 1'b0;
      end
    end
  end

  // last_id still names the current owner when the transfer completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'd0;
      rd_id    <= 1'b0;
    end else begin
      rd_valid <= done;
      if (done) begin
        rd_data <= rx_sh;
        rd_id   <= last_id;
      end
    end
  end

endmodule

// File: tb/tb_spi_lfsr_master.sv
// ---------------------------------------------------------------------------
// tb_spi_lfsr_master
//
// Two instances: CLK_DIV=4 and CLK_DIV=2. Each has a mode-0 slave model
// and a scoreboard: at every grant the bench's own round-robin model and
// slave byte produce an expected record, popped and compared at rd_valid.
// ---------------------------------------------------------------------------
module tb_spi_lfsr_master;

  typedef struct {
    logic       id;
    logic [7:0] rx;
    logic [7:0] tx;
    int         t_gnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] req      [2];
  logic [7:0] tx0      [2];
  logic [7:0] tx1      [2];
  logic [1:0] gnt      [2];
  logic       busy     [2];
  logic       rd_valid [2];
  logic [7:0] rd_data  [2];
  logic       rd_id    [2];
  logic       cs       [2];
  logic       sclk     [2];
  logic       mosi     [2];
  logic       miso     [2];
  logic [7:0] slv_byte [2];

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : 2;

    spi_lfsr_master #(.CLK_DIV(D)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req[g]),
      .tx_data0 (tx0[g]),
      .tx_data1 (tx1[g]),
      .gnt      (gnt[g]),
      .busy     (busy[g]),
      .rd_valid (rd_valid[g]),
      .rd_data  (rd_data[g]),
      .rd_id    (rd_id[g]),
      .spi_cs   (cs[g]),
      .spi_sclk (sclk[g]),
      .spi_mosi (mosi[g]),
      .spi_miso (miso[g])
    );

    logic [7:0] slv_cur  = 8'd0;
    logic [7:0] slv_sh   = 8'd0;
    logic [7:0] mosi_cap = 8'd0;
    int         rises    = 0;
    logic [1:0] req_smp  = 2'b00;
    logic       last_m   = 1'b1;
    int         last_t   = -1;
    logic       w_m;
    exp_t       e_m;
    exp_t       sb_q [$];

    initial miso[g] = 1'b0;

    // Mode-0 slave: MSB out at cs fall, shift on SCLK fall, capture MOSI on rise.
    always @(negedge cs[g]) begin
      slv_cur = slv_byte[g];
      slv_sh  = slv_byte[g];
      miso[g] = slv_sh[7];
      rises   = 0;
    end
    always @(posedge sclk[g]) begin
      mosi_cap = {mosi_cap[6:0], mosi[g]};
      rises++;
    end
    always @(negedge sclk[g]) begin
      slv_sh  = {slv_sh[6:0], 1'b0};
      miso[g] = slv_sh[7];
    end

    always @(posedge clk) req_smp = req[g];

    always @(negedge rst_n) begin
      sb_q.delete();
      last_m = 1'b1;
      last_t = -1;
    end

    always @(negedge clk) begin
      if (rst_n) begin
        if (gnt[g] != 2'b00) begin
          w_m = (req_smp == 2'b10) ? 1'b1 : (req_smp == 2'b01) ? 1'b0 : ~last_m;
          chk($sformatf("g%0d_gnt_req", g), (req_smp != 2'b00), 1'b1);
          chk($sformatf("g%0d_gnt_win", g), gnt[g], w_m ? 2'b10 : 2'b01);
          if (last_t >= 0)
            chk($sformatf("g%0d_gnt_gap_min", g), (cyc - last_t >= 17 * D + 1), 1'b1);
          last_m = w_m;
          last_t = cyc;
          sb_q.push_back('{w_m, slv_cur, w_m ? tx1[g] : tx0[g], cyc});
        end
        if (rd_valid[g]) begin
          if (sb_q.size() == 0) begin
            chk($sformatf("g%0d_rd_unexpected", g), rd_valid[g], 1'b0);
          end else begin
            e_m = sb_q.pop_front();
            chk($sformatf("g%0d_rd_data", g), rd_data[g], e_m.rx);
            chk($sformatf("g%0d_rd_id", g), rd_id[g], e_m.id);
            chk($sformatf("g%0d_mosi_byte", g), mosi_cap, e_m.tx);
            chk($sformatf("g%0d_sclk_rises", g), rises, 8);
            chk($sformatf("g%0d_rd_latency", g), cyc - e_m.t_gnt, 16 * D);
          end
        end
      end
    end
  end

  task automatic wait_gnt(input int g, input int budget, output logic [1:0] gv);
    gv = 2'b00;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt[g] != 2'b00) begin
        gv = gnt[g];
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_gnt%0d: no grant within %0d cycles", g, budget);
  endtask

  task automatic wait_idle(input int g, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy[g]) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL wait_idle%0d: still busy after %0d cycles", g, budget);
  endtask

  logic [1:0] gv;
  int         t0, tprev, busy_lo, seen_gnt, rv_at, rv_cnt, cs_hi;

  initial begin
    rst_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      req[g] = 2'b00; tx0[g] = 8'h00; tx1[g] = 8'h00; slv_byte[g] = 8'h00;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_cs", cs[g], 1'b1);
      chk("rst_sclk", sclk[g], 1'b0);
      chk("rst_mosi", mosi[g], 1'b0);
      chk("rst_gnt", gnt[g], 2'b00);
      chk("rst_busy", busy[g], 1'b0);
      chk("rst_rd", {rd_valid[g], rd_id[g], rd_data[g]}, 10'h000);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single transfer from requester 0; a req[1] pulse mid-transfer must be ignored.
    tx0[0] = 8'hA5; slv_byte[0] = 8'h3C; req[0] = 2'b01;
    @(negedge clk);
    req[0] = 2'b00;
    chk("t1_gnt", gnt[0], 2'b01);
    busy_lo = 0; seen_gnt = 0; rv_at = -1; rv_cnt = 0;
    for (int i = 1; i < 17 * 4; i++) begin
      if (i == 10) req[0] = 2'b10;
      if (i == 11) req[0] = 2'b00;
      @(negedge clk);
      if (!busy[0]) busy_lo++;
      if (gnt[0] != 2'b00) seen_gnt++;
      if (rd_valid[0]) begin
        rv_cnt++; rv_at = i;
        chk("t1_rd_data", rd_data[0], 8'h3C);
      end
    end
    chk("t1_busy_held", busy_lo, 0);
    chk("t1_rd_cycle", rv_at, 64);
    chk("t1_rd_count", rv_cnt, 1);
    @(negedge clk);
    chk("t1_idle_at_17d", busy[0], 1'b0);
    repeat (3) @(negedge clk) if (gnt[0] != 2'b00) seen_gnt++;
    chk("t1_no_gnt_busy_req", seen_gnt, 0);

    // Requester 1 alone, then a tie on the next IDLE goes to requester 0.
    req[0] = 2'b10; tx1[0] = 8'h96; slv_byte[0] = 8'hE7;
    wait_gnt(0, 4, gv);
    chk("t3_gnt1", gv, 2'b10);
    t0 = cyc;
    req[0] = 2'b11; slv_byte[0] = 8'h42;
    wait_gnt(0, 100, gv);
    chk("t3_tie_gnt", gv, 2'b01);
    chk("t3_gap", cyc - t0, 69);
    req[0] = 2'b00;
    wait_idle(0, 100);
    repeat (2) @(negedge clk);

    // Reset in cycle 30 of a transfer (SCLK is high there).
    req[0] = 2'b01; tx0[0] = 8'h5A; slv_byte[0] = 8'h11;
    wait_gnt(0, 4, gv);
    chk("t4_gnt", gv, 2'b01);
    req[0] = 2'b00;
    repeat (30) @(negedge clk);
    chk("t4_sclk_pre", sclk[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_cs_async", cs[0], 1'b1);
    chk("t4_sclk_async", sclk[0], 1'b0);
    chk("t4_busy_async", busy[0], 1'b0);
    chk("t4_rd_data_clr", rd_data[0], 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Held tie after reset: 01,10,01,10 spaced 17D+1.
    req[0] = 2'b11; tx0[0] = 8'h5A; tx1[0] = 8'hC3; slv_byte[0] = 8'h3C;
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(0, 100, gv);
      chk($sformatf("t2_gnt%0d", k), gv, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k > 0) chk($sformatf("t2_gap%0d", k), cyc - tprev, 69);
      tprev = cyc;
      slv_byte[0] = 8'(8'h1D + k * 8'h37);
      if (k == 3) req[0] = 2'b00;
    end
    wait_idle(0, 100);
    repeat (2) @(negedge clk);

    // CLK_DIV=2 back-to-back: FF then 00, cs gap D+1.
    req[1] = 2'b01; tx0[1] = 8'h81; slv_byte[1] = 8'hFF;
    wait_gnt(1, 4, gv);
    chk("t6_gnt1", gv, 2'b01);
    t0 = cyc; slv_byte[1] = 8'h00;
    cs_hi = 0; rv_at = -1; gv = 2'b00;
    for (int i = 1; i <= 40 && gv == 2'b00; i++) begin
      @(negedge clk);
      if (cs[1]) cs_hi++;
      if (rd_valid[1]) begin
        rv_at = i;
        chk("t6_rd_ff", rd_data[1], 8'hFF);
      end
      if (gnt[1] != 2'b00) gv = gnt[1];
    end
    req[1] = 2'b00;
    chk("t6_rd_cycle", rv_at, 32);
    chk("t6_cs_gap", cs_hi, 3);
    chk("t6_gnt2", gv, 2'b01);
    chk("t6_gap", cyc - t0, 35);
    wait_idle(1, 60);
    repeat (2) @(negedge clk);

    chk("sb0_drained", g_dut[0].sb_q.size(), 0);
    chk("sb1_drained", g_dut[1].sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
